// File: rtl/tmul_pkg.sv
// Shared definitions for the tile-multiply sequencing controller: FSM states,
// default geometry and an index-width helper.
package tmul_pkg;

    localparam int STAGES_DEF     = 16;
    localparam int MAX_ROWS_DEF   = 16;
    localparam int CRED_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } tmul_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tmul_credit_cnt.sv
// Credit counter for the downstream result buffer: starts full, one credit per
// injected row, one back per cred_ret; a return while already full sets a sticky error.
module tmul_credit_cnt
    import tmul_pkg::*;
#(
    parameter int DEPTH = CRED_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic consume_i,
    input  logic ret_i,
    output logic avail_o,
    output logic err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          take;

    // Injection is only legal with a credit in hand; a same-cycle return
    // cannot fund it, it only becomes usable next cycle.
    assign take    = consume_i && (count_q != '0);
    assign avail_o = (count_q != '0);
    assign err_o   = err_q;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (take && !ret_i) begin
            count_d = count_q - CW'(1);
        end else if (!take && ret_i) begin
            if (count_q == CW'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CW'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/tmul_seq_ctrl.sv
// Row sequencer for the FMA tile-multiply pipeline: injects A-tile rows into a
// STAGES-deep shift register under result-buffer credit. Optional perf counters: TMUL_CTRL_PERF_EN.
module tmul_seq_ctrl
    import tmul_pkg::*;
#(
    parameter  int STAGES     = STAGES_DEF,
    parameter  int MAX_ROWS   = MAX_ROWS_DEF,
    parameter  int CRED_DEPTH = CRED_DEPTH_DEF,
    localparam int RW         = idx_w(MAX_ROWS),
    localparam int CNTW       = $clog2(MAX_ROWS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CNTW-1:0]           cmd_rows,
    output logic [STAGES-1:0]         stage_vld,
    output logic [STAGES-1:0][RW-1:0] stage_row,
    output logic                      res_valid,
    output logic [RW-1:0]             res_row,
    output logic                      res_last,
    input  logic                      cred_ret,
    output logic                      done,
    output logic                      err_cred
`ifdef TMUL_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_busy,
    output logic [31:0]               perf_stall
`endif
);

    tmul_state_e state_q, state_d;

    logic [CNTW-1:0] rows_q, rows_d;
    logic [CNTW-1:0] row_cnt_q, row_cnt_d;
    logic            zero_done_q, zero_done_d;

    logic cmd_accept, issue_en, drain_done, cred_avail;
    logic inject, last_inj, pipe_empty;

    logic [STAGES-1:1]         vld_q;
    logic [STAGES-1:1][RW-1:0] row_q;
    logic [STAGES-1:1]         last_q;
    logic [STAGES-1:0]         stage_last;
    logic [RW-1:0]             row0;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign inject     = issue_en && cred_avail;
    assign last_inj   = inject && (row_cnt_q == rows_q - CNTW'(1));
    assign row0       = inject ? row_cnt_q[RW-1:0] : '0;

    // Stage 0 is the injection point itself; the rest is a free-running shift.
    assign stage_vld  = {vld_q, inject};
    assign stage_row  = {row_q, row0};
    assign stage_last = {last_q, last_inj};
    assign pipe_empty = ~|stage_vld;

    assign res_valid = stage_vld[STAGES-1];
    assign res_row   = stage_row[STAGES-1];
    assign res_last  = stage_last[STAGES-1];
    assign done      = drain_done || zero_done_q;

    tmul_credit_cnt #(
        .DEPTH (CRED_DEPTH)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .consume_i (inject),
        .ret_i     (cred_ret),
        .avail_o   (cred_avail),
        .err_o     (err_cred)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_accept && (cmd_rows != '0)) state_d = ST_ISSUE;
            ST_ISSUE: if (last_inj)                       state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty)                     state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        issue_en   = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE:  cmd_ready  = 1'b1;
            ST_ISSUE: issue_en   = 1'b1;
            ST_DRAIN: drain_done = pipe_empty;
            default:  cmd_ready  = 1'b0;
        endcase
    end

    // Oversized commands are clamped to the tile height.
    always_comb begin
        rows_d      = rows_q;
        row_cnt_d   = row_cnt_q;
        zero_done_d = cmd_accept && (cmd_rows == '0);
        if (cmd_accept) begin
            rows_d    = (cmd_rows > CNTW'(MAX_ROWS)) ? CNTW'(MAX_ROWS) : cmd_rows;
            row_cnt_d = '0;
        end else if (inject) begin
            row_cnt_d = row_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q      <= '0;
            row_cnt_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            rows_q      <= rows_d;
            row_cnt_q   <= row_cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[gi]  <= 1'b0;
                    row_q[gi]  <= '0;
                    last_q[gi] <= 1'b0;
                end else begin
                    vld_q[gi]  <= stage_vld[gi-1];
                    row_q[gi]  <= stage_row[gi-1];
                    last_q[gi] <= stage_last[gi-1];
                end
            end
        end
    endgenerate

`ifdef TMUL_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (issue_en && !cred_avail && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_tmul_seq_ctrl.sv
// Scoreboard bench for tmul_seq_ctrl: a cycle-level reference of the row/credit
// rules predicts injections, results and done; a separate monitor checks results.
module tb_tmul_seq_ctrl;

    localparam int STAGES = 16;
    localparam int CRED   = 16;
    localparam int RW     = 4;
    localparam int CNTW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cred_ret = 1'b0;
    logic [CNTW-1:0] cmd_rows = '0;
    logic cmd_ready, res_valid, res_last, done, err_cred;
    logic [STAGES-1:0] stage_vld;
    logic [STAGES-1:0][RW-1:0] stage_row;
    logic [RW-1:0] res_row;
`ifdef TMUL_CTRL_PERF_EN
    logic [31:0] perf_busy, perf_stall;
`endif

    tmul_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rows  (cmd_rows),
        .stage_vld (stage_vld),
        .stage_row (stage_row),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_last  (res_last),
        .cred_ret  (cred_ret),
        .done      (done),
        .err_cred  (err_cred)
`ifdef TMUL_CTRL_PERF_EN
        ,
        .perf_busy (perf_busy),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int row;
        bit last;
        int due;
    } res_t;

    res_t exp_q[$];
    int   hist[int];   // cycle -> row injected at stage 0 in that cycle

    bit chk_en      = 1'b0;
    bit m_busy      = 1'b0;
    bit m_err       = 1'b0;
    int m_cred      = CRED;
    int m_rows_left = 0;
    int m_next_row  = 0;
    int m_done_cyc  = -1;

    function automatic bit inj_now();
        return (m_rows_left > 0) && (m_cred > 0);
    endfunction

    always begin : model
        bit inj;
        logic [STAGES-1:0] ev;
        @(negedge clk);
        #1;
        inj = chk_en && inj_now();
        if (chk_en) begin
            if (inj) hist[cyc] = m_next_row;
            if (hist.exists(cyc - STAGES)) hist.delete(cyc - STAGES);
            for (int k = 0; k < STAGES; k++) ev[k] = hist.exists(cyc - k);
            chk("stage_vld", int'(stage_vld), int'(ev));
            for (int k = 0; k < STAGES; k++)
                if (ev[k]) chk($sformatf("stage_row[%0d]", k), int'(stage_row[k]), hist[cyc - k]);
            chk("cmd_ready", int'(cmd_ready), int'(!m_busy));
            chk("done", int'(done), int'(m_done_cyc == cyc));
            chk("err_cred", int'(err_cred), int'(m_err));
            if (inj) exp_q.push_back('{row: m_next_row, last: (m_rows_left == 1), due: cyc + STAGES - 1});
        end
        if (rst) begin
            m_busy = 0; m_err = 0; m_cred = CRED; m_rows_left = 0; m_next_row = 0;
            m_done_cyc = -1; exp_q.delete(); hist.delete(); chk_en = 1'b1;
        end else if (chk_en) begin
            if (cyc == m_done_cyc) begin
                m_busy = 0; m_done_cyc = -1;
            end
            if (cmd_valid && !m_busy) begin
                if (cmd_rows == 0) m_done_cyc = cyc + 1;
                else begin
                    m_busy = 1; m_rows_left = int'(cmd_rows); m_next_row = 0;
                end
            end
            if (inj) begin
                m_rows_left--; m_next_row++;
                if (m_rows_left == 0) m_done_cyc = cyc + STAGES;
            end
            if (inj && !cred_ret) m_cred--;
            else if (!inj && cred_ret) begin
                if (m_cred == CRED) m_err = 1;
                else m_cred++;
            end
        end
    end

    // ---------------- monitor ----------------
    int done_cnt = 0;
    int done_cyc = 0;
    int inj_cnt  = 0;

    always begin : monitor
        res_t r;
        @(negedge clk);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (stage_vld[0]) inj_cnt++;
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                chk("res_valid", int'(res_valid), 1);
                chk("res_row", int'(res_row), r.row);
                chk("res_last", int'(res_last), int'(r.last));
            end else begin
                chk("res_valid_idle", int'(res_valid), 0);
            end
        end
    end

    // ---------------- credit-return driver ----------------
    int ret_mode = 0;   // 0 none, 1 random, 2 on every injection
    int ret_req  = 0;   // explicit pulses still to send

    always begin : cred_drv
        @(posedge clk);
        #1;
        if (rst) cred_ret = 1'b0;
        else if (ret_req > 0) begin
            if (!cred_ret) begin cred_ret = 1'b1; ret_req--; end
            else cred_ret = 1'b0;
        end else begin
            case (ret_mode)
                1:       cred_ret = (m_cred < CRED || inj_now()) && ($urandom_range(0, 2) == 0);
                2:       cred_ret = inj_now();
                default: cred_ret = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rows, output int acc);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_rows  = CNTW'(rows);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin n_tests++; n_fail++; $display("FAIL cmd_accept_timeout"); end
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, output int dc);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt > start_cnt) begin ok = 1; break; end
        end
        if (!ok) begin n_tests++; n_fail++; $display("FAIL done_timeout: got none, expected a done pulse"); end
        dc = done_cyc;
        tick();
    endtask

    task automatic run_tile(input int rows, output int lat);
        int acc, dc, dcnt;
        dcnt = done_cnt;
        issue(rows, acc);
        wait_done(dcnt, dc);
        lat = dc - acc;
        $display("[TB] tile rows=%0d accept@%0d done@%0d", rows, acc, dc);
    endtask

    task automatic refill();
        ret_req = CRED - m_cred;
        for (int i = 0; i < 200; i++) begin
            if (ret_req == 0 && !cred_ret) break;
            tick();
        end
        tick();
        tick();
    endtask

    initial begin
        int lat, acc, dc, dcnt, ic;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        run_tile(16, lat);
        chk("lat_rows16_full_credit", lat, 32);
        refill();

        run_tile(0, lat);
        chk("lat_rows0", lat, 1);

        ret_mode = 1;
        for (int i = 0; i < 24; i++) run_tile(int'($urandom_range(0, 16)), lat);
        ret_mode = 0;
        refill();

        // Leave four credits, then an 8-row tile must stall after four rows.
        run_tile(12, lat);
        chk("lat_rows12", lat, 28);
        ic = inj_cnt;
        dcnt = done_cnt;
        issue(8, acc);
        repeat (30) tick();
        chk("inj_before_ret", inj_cnt - ic, 4);
        chk("no_done_while_stalled", done_cnt - dcnt, 0);
        ret_req = 4;
        wait_done(dcnt, dc);
        chk("inj_after_ret", inj_cnt - ic, 8);
        $display("[TB] stalled tile rows=8 accept@%0d done@%0d", acc, dc);
        refill();

        // Reset while row 5 is being injected.
        dcnt = done_cnt;
        issue(16, acc);
        for (int i = 0; i < 100; i++) begin
            if (m_next_row == 5 && inj_now()) break;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stage_vld_after_rst", int'(stage_vld), 0);
        repeat (20) tick();
        chk("no_done_after_rst", done_cnt - dcnt, 0);
        $display("[TB] mid-tile reset after accept@%0d", acc);
        run_tile(16, lat);
        chk("lat_after_rst_full_credit", lat, 32);
        refill();

        // Return at full credit, then simultaneous inject+return.
        ret_req = 1;
        repeat (4) tick();
        chk("err_cred_set", int'(err_cred), 1);
        ret_mode = 2;
        run_tile(16, lat);
        chk("lat_inject_with_ret", lat, 32);
        ret_mode = 0;
        run_tile(16, lat);
        chk("lat_credits_unchanged", lat, 32);
        chk("err_cred_held", int'(err_cred), 1);
        refill();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("err_cred_cleared", int'(err_cred), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
